// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the 16-bit CPU: decodes the latched opcode
// into datapath controls, waits on data-memory ready and counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [3:0]         opcode,
  input  logic               MemReady,
  output logic               RegDst,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               ALUSrc,
  output logic [1:0]         ALUOp,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               Illegal,
  output logic               Halted,
  output logic               Fault,
  output logic [2:0]         State,
  output logic [COUNT_W-1:0] InstrCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SLTI = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]         state_reg, state_next;
  logic [3:0]         opreg;
  logic [7:0]         wait_cnt_reg;
  logic [COUNT_W-1:0] instr_count_reg;
  logic               fault_reg;
  logic               mem_timeout;

  // Timeout fires on the last permitted stalled MEM cycle, so MEM lasts MEM_TIMEOUT cycles.
  assign mem_timeout = (state_reg == S_MEM) && !MemReady && (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      opreg           <= 4'd0;
      wait_cnt_reg    <= 8'd0;
      instr_count_reg <= '0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        opreg <= opcode;
      if (state_reg != S_MEM)
        wait_cnt_reg <= 8'd0;
      else if (!MemReady)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (PCWrite)
        instr_count_reg <= instr_count_reg + 1'b1;
      if (mem_timeout)
        fault_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (opreg)
          OP_R, OP_ADDI, OP_SLTI: state_next = S_WB;
          OP_LW, OP_SW:           state_next = S_MEM;
          default:                state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_timeout)
          state_next = S_HALT;
        else if (!MemReady)
          state_next = S_MEM;
        else if (opreg == OP_SW)
          state_next = S_FETCH;
        else
          state_next = S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    Illegal  = 1'b0;
    case (state_reg)
      S_FETCH: IRWrite = 1'b1;
      S_EXEC, S_WB: begin
        // WB repeats the EXEC controls so the ALU result stays stable during write-back.
        case (opreg)
          OP_R: begin
            RegDst = 1'b1;
            ALUOp  = 2'b10;
          end
          OP_ADDI, OP_LW, OP_SW: ALUSrc = 1'b1;
          OP_SLTI: begin
            ALUSrc = 1'b1;
            ALUOp  = 2'b11;
          end
          OP_BEQ: begin
            Branch  = 1'b1;
            ALUOp   = 2'b01;
            PCWrite = 1'b1;
          end
          default: begin
            PCWrite = 1'b1;
            Illegal = 1'b1;
          end
        endcase
        if (state_reg == S_WB) begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          Illegal  = 1'b0;
          if (opreg == OP_LW) begin
            MemToReg = 1'b1;
            MemRead  = 1'b1;
          end
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (opreg == OP_LW);
        MemWrite = (opreg == OP_SW);
        PCWrite  = (opreg == OP_SW) && MemReady;
      end
      default: ;
    endcase
  end

  assign Halted     = (state_reg == S_HALT);
  assign Fault      = fault_reg;
  assign State      = state_reg;
  assign InstrCount = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a per-instruction trace model built
// from the instruction-class rules is compared cycle by cycle against the DUT.
module tb_multicycle_control_unit;

  localparam int TO = 15;
  localparam int CW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [3:0]    opcode = 4'd0;
  logic          MemReady = 1'b0;
  logic          RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc;
  logic [1:0]    ALUOp;
  logic          PCWrite, IRWrite, Illegal, Halted, Fault;
  logic [2:0]    State;
  logic [CW-1:0] InstrCount;

  always #5 Clock = ~Clock;

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .COUNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .MemReady(MemReady),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .Illegal(Illegal), .Halted(Halted),
    .Fault(Fault), .State(State), .InstrCount(InstrCount)
  );

  // {RegDst,Branch,MemRead,MemWrite,RegWrite,MemToReg,ALUSrc,ALUOp,PCWrite,IRWrite,Illegal,Halted,Fault}
  logic [13:0] ctl_obs;
  assign ctl_obs = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
                    ALUOp, PCWrite, IRWrite, Illegal, Halted, Fault};

  typedef struct {
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [3:0]  op;
    logic        mr;
  } step_t;

  step_t         q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_count;
  int            obs_cycles, obs_memread, obs_memwrite, obs_pcw, obs_regwrite, obs_ill;

  function automatic logic [13:0] mk(input logic rd, br, mrd, mwr, rw, m2r, src,
                                     input logic [1:0] aop,
                                     input logic pcw, irw, ill, hlt, flt);
    return {rd, br, mrd, mwr, rw, m2r, src, aop, pcw, irw, ill, hlt, flt};
  endfunction

  // Inputs outside their meaningful state are randomized to prove they are ignored.
  task automatic push(input logic [2:0] st, input logic [13:0] ctl,
                      input logic [3:0] op, input logic mr);
    step_t s;
    s.st  = st;
    s.ctl = ctl;
    s.op  = (st == 3'd2) ? op : 4'($urandom);
    s.mr  = (st == 3'd4) ? mr : 1'($urandom);
    q.push_back(s);
  endtask

  // Expected trace of one instruction from FETCH; w = MemReady-low cycles in MEM.
  task automatic build(input logic [3:0] op, input int w);
    logic is_lw;
    push(3'd1, mk(0,0,0,0,0,0,0,2'b00,0,1,0,0,0), 4'd0, 1'b0);
    push(3'd2, 14'd0, op, 1'b0);
    case (op)
      4'b0001: push(3'd6, mk(0,0,0,0,0,0,0,2'b00,0,0,0,1,0), 4'd0, 1'b0);
      4'b0000: begin
        push(3'd3, mk(1,0,0,0,0,0,0,2'b10,0,0,0,0,0), 4'd0, 1'b0);
        push(3'd5, mk(1,0,0,0,1,0,0,2'b10,1,0,0,0,0), 4'd0, 1'b0);
      end
      4'b0100: begin
        push(3'd3, mk(0,0,0,0,0,0,1,2'b00,0,0,0,0,0), 4'd0, 1'b0);
        push(3'd5, mk(0,0,0,0,1,0,1,2'b00,1,0,0,0,0), 4'd0, 1'b0);
      end
      4'b0101: begin
        push(3'd3, mk(0,0,0,0,0,0,1,2'b11,0,0,0,0,0), 4'd0, 1'b0);
        push(3'd5, mk(0,0,0,0,1,0,1,2'b11,1,0,0,0,0), 4'd0, 1'b0);
      end
      4'b1000: push(3'd3, mk(0,1,0,0,0,0,0,2'b01,1,0,0,0,0), 4'd0, 1'b0);
      4'b1011, 4'b1111: begin
        is_lw = (op == 4'b1011);
        push(3'd3, mk(0,0,0,0,0,0,1,2'b00,0,0,0,0,0), 4'd0, 1'b0);
        for (int k = 0; k <= w && k < TO; k++)
          push(3'd4, mk(0,0,is_lw,!is_lw,0,0,1,2'b00,(!is_lw && k == w),0,0,0,0),
               4'd0, (k == w));
        if (w >= TO)
          push(3'd6, mk(0,0,0,0,0,0,0,2'b00,0,0,0,1,1), 4'd0, 1'b0);
        else if (is_lw)
          push(3'd5, mk(0,0,1,0,1,1,1,2'b00,1,0,0,0,0), 4'd0, 1'b0);
      end
      default: push(3'd3, mk(0,0,0,0,0,0,0,2'b00,1,0,1,0,0), 4'd0, 1'b0);
    endcase
  endtask

  // Plays n queued steps (all if n < 0) and scores every cycle against the model.
  task automatic run_steps(input int n);
    step_t s;
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      @(posedge Clock);
      #1;
      opcode   = s.op;
      MemReady = s.mr;
      #1;
      obs_cycles++;
      obs_memread  += int'(MemRead);
      obs_memwrite += int'(MemWrite);
      obs_pcw      += int'(PCWrite);
      obs_regwrite += int'(RegWrite);
      obs_ill      += int'(Illegal);
      n_cmp += 3;
      if (State !== s.st) begin
        n_bad++;
        $display("FAIL state: got %0d expected %0d", State, s.st);
      end
      if (ctl_obs !== s.ctl) begin
        n_bad++;
        $display("FAIL controls (state %0d): got %b expected %b", s.st, ctl_obs, s.ctl);
      end
      if (InstrCount !== exp_count) begin
        n_bad++;
        $display("FAIL instr_count: got %0d expected %0d", InstrCount, exp_count);
      end
      if (s.ctl[4]) exp_count = exp_count + 1'b1;
      k++;
    end
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset  = 1'b1;
    opcode = 4'($urandom);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    q.delete();
    exp_count = '0;
    obs_cycles = 0; obs_memread = 0; obs_memwrite = 0;
    obs_pcw = 0; obs_regwrite = 0; obs_ill = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 3;
    if (State !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", State); end
    if (ctl_obs !== 14'd0) begin n_bad++; $display("FAIL reset_outputs: got %b expected 0", ctl_obs); end
    if (InstrCount !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", InstrCount); end
    $display("reset: state=%0d outputs=%b count=%0d", State, ctl_obs, InstrCount);
  endtask

  task automatic test_rtype();
    do_reset();
    build(4'b0000, 0);
    run_steps(-1);
    @(posedge Clock);
    #2;
    n_cmp += 4;
    if (obs_cycles !== 4) begin n_bad++; $display("FAIL rtype_cpi: got %0d expected 4", obs_cycles); end
    if (obs_regwrite !== 1) begin n_bad++; $display("FAIL rtype_regwrite: got %0d expected 1", obs_regwrite); end
    if (obs_pcw !== 1) begin n_bad++; $display("FAIL rtype_pcwrite: got %0d expected 1", obs_pcw); end
    if (InstrCount !== 8'd1) begin n_bad++; $display("FAIL rtype_count: got %0d expected 1", InstrCount); end
    $display("rtype: cycles=%0d count=%0d", obs_cycles, InstrCount);
  endtask

  task automatic test_lw();
    do_reset();
    build(4'b1011, 3);
    run_steps(-1);
    n_cmp += 2;
    if (obs_cycles !== 8) begin n_bad++; $display("FAIL lw_cpi: got %0d expected 8", obs_cycles); end
    if (obs_memread !== 5) begin n_bad++; $display("FAIL lw_memread_cycles: got %0d expected 5", obs_memread); end
    $display("lw w=3: cycles=%0d memread_cycles=%0d", obs_cycles, obs_memread);
  endtask

  task automatic test_sw();
    do_reset();
    build(4'b1111, 1);
    run_steps(-1);
    n_cmp += 3;
    if (obs_cycles !== 5) begin n_bad++; $display("FAIL sw_cpi: got %0d expected 5", obs_cycles); end
    if (obs_memwrite !== 2) begin n_bad++; $display("FAIL sw_memwrite_cycles: got %0d expected 2", obs_memwrite); end
    if (obs_regwrite !== 0) begin n_bad++; $display("FAIL sw_regwrite: got %0d expected 0", obs_regwrite); end
    $display("sw w=1: cycles=%0d memwrite_cycles=%0d", obs_cycles, obs_memwrite);
  endtask

  task automatic test_beq_illegal();
    do_reset();
    build(4'b1000, 0);
    build(4'b0111, 0);
    run_steps(-1);
    @(posedge Clock);
    #2;
    n_cmp += 3;
    if (obs_cycles !== 6) begin n_bad++; $display("FAIL beq_ill_cycles: got %0d expected 6", obs_cycles); end
    if (obs_ill !== 1) begin n_bad++; $display("FAIL illegal_pulses: got %0d expected 1", obs_ill); end
    if (InstrCount !== 8'd2) begin n_bad++; $display("FAIL beq_ill_count: got %0d expected 2", InstrCount); end
    $display("beq+illegal: cycles=%0d count=%0d", obs_cycles, InstrCount);
  endtask

  task automatic test_halt();
    do_reset();
    build(4'b0001, 0);
    for (int i = 0; i < 4; i++) push(3'd6, mk(0,0,0,0,0,0,0,2'b00,0,0,0,1,0), 4'd0, 1'b0);
    run_steps(-1);
    n_cmp += 1;
    if (obs_pcw !== 0) begin n_bad++; $display("FAIL halt_pcwrite: got %0d expected 0", obs_pcw); end
    $display("halt: state=%0d halted=%0d", State, Halted);
  endtask

  task automatic test_timeout();
    do_reset();
    build(4'b1111, TO);
    for (int i = 0; i < 3; i++) push(3'd6, mk(0,0,0,0,0,0,0,2'b00,0,0,0,1,1), 4'd0, 1'b0);
    run_steps(-1);
    n_cmp += 2;
    if (obs_memwrite !== TO) begin n_bad++; $display("FAIL timeout_mem_cycles: got %0d expected %0d", obs_memwrite, TO); end
    if ({State, Fault, Halted, MemWrite} !== {3'd6, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_halt: got state=%0d fault=%0d halted=%0d memwrite=%0d expected 6/1/1/0",
               State, Fault, Halted, MemWrite);
    end
    do_reset();
    n_cmp += 1;
    if ({State, Fault} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_reset: got state=%0d fault=%0d expected 0/0", State, Fault);
    end
    $display("timeout: after reset state=%0d fault=%0d", State, Fault);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < (1 << CW); i++) build(4'b0111, 0);
    run_steps(-1);
    @(posedge Clock);
    #2;
    n_cmp += 1;
    if (InstrCount !== '0) begin n_bad++; $display("FAIL count_wrap: got %0d expected 0", InstrCount); end
    $display("wrap: %0d retired, count=%0d", obs_pcw, InstrCount);
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    build(4'b0000, 0);
    build(4'b1111, 6);
    run_steps(4 + 5);
    q.delete();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    n_cmp += 1;
    if (MemWrite !== 1'b1) begin n_bad++; $display("FAIL mid_mem_prereset: got memwrite=%0d expected 1", MemWrite); end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    n_cmp += 1;
    if ({State, ctl_obs, InstrCount} !== {3'd0, 14'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL mid_mem_reset: got state=%0d outputs=%b count=%0d expected all 0",
               State, ctl_obs, InstrCount);
    end
    $display("reset mid-MEM: state=%0d outputs=%b", State, ctl_obs);
  endtask

  task automatic test_random();
    logic [3:0] ops [8] = '{4'b0000, 4'b0100, 4'b0101, 4'b1011, 4'b1111, 4'b1000, 4'b0111, 4'b1100};
    logic [3:0] op;
    int w;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      w  = $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) op = 4'($urandom);
      if (op == 4'b0001) op = 4'b0000;
      build(op, w);
    end
    run_steps(-1);
    $display("random: %0d cycles, %0d retired", obs_cycles, obs_pcw);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq_illegal();
    test_halt();
    test_timeout();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
